// File: rtl/gpi_input_conditioner.sv
// ---------------------------------------------------------------------------
// gpi_input_conditioner
//
// Core-side conditioning stage for a GPI pad cell with a pulldown input.
// Turns on the pad input buffer, forwards the Schmitt-trigger setting,
// synchronises the asynchronous pad level, debounces it, and produces:
//   - a filtered level,
//   - single-cycle rise and fall pulses,
//   - a sticky, maskable event flag.
// The block sits between the IO ring and the GPIO register block.
//
// Parameters
//   SYNC_STAGES  synchroniser depth (>= 2)
//   CNT_W        debounce counter / threshold width
//   RST_VAL      reset level of the synchroniser and LVL_O
//
// Ports
//   CLK_I       in   core clock
//   RSTN_I      in   synchronous reset, active-low
//   EN_I        in   input enable request
//   STE_CFG_I   in   Schmitt-trigger config, forwarded to the pad
//   DBNC_I      in   debounce threshold; 0 disables filtering
//   EVT_MASK_I  in   [0] rise raises IRQ, [1] fall raises IRQ
//   IRQ_CLR_I   in   clears the sticky IRQ
//   DI_I        in   pad receiver output, asynchronous
//   IE_O        out  pad input enable
//   STE_O       out  pad Schmitt-trigger select
//   LVL_O       out  debounced level
//   RISE_O      out  one-cycle pulse on a filtered 0->1
//   FALL_O      out  one-cycle pulse on a filtered 1->0
//   IRQ_O       out  sticky event flag
// ---------------------------------------------------------------------------
module gpi_input_conditioner #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 8,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic             CLK_I,
    input  logic             RSTN_I,
    input  logic             EN_I,
    input  logic [1:0]       STE_CFG_I,
    input  logic [CNT_W-1:0] DBNC_I,
    input  logic [1:0]       EVT_MASK_I,
    input  logic             IRQ_CLR_I,
    input  logic             DI_I,
    output logic             IE_O,
    output logic [1:0]       STE_O,
    output logic             LVL_O,
    output logic             RISE_O,
    output logic             FALL_O,
    output logic             IRQ_O
);

    // The counter doubles as the settle timer; the settle phase lasts
    // SYNC_STAGES+1 cycles, so its last cycle is the one where cnt reaches
    // SYNC_STAGES.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SYNC_STAGES);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   ie_q, ie_d;
    logic                   irq_q, irq_d;
    logic [1:0]             ste_q;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain. It keeps running in every state so that s
    // already tracks the pad by the time the settle phase ends.
    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], DI_I};
        end
    end

    // Pad Schmitt-trigger select, registered straight from the config input.
    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            ste_q <= 2'b00;
        end else begin
            ste_q <= STE_CFG_I;
        end
    end

    // State register and all registered outputs. Everything the FSM produces
    // is flopped so the pad controls and the event outputs are glitch-free.
    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            lvl_q   <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            ie_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            ie_q    <= ie_d;
            irq_q   <= irq_d;
        end
    end

    // Next-state and output logic.
    // OFF: pad disabled, level frozen.
    // SETTLE: waits for the freshly enabled pad value to pass through the
    //         synchroniser, then adopts it silently, with no edge pulse.
    // RUN: a mismatch between s and the filtered level must persist until
    //      the counter has reached the threshold before the level follows.
    //      Using >= means a threshold lowered below the current count takes
    //      effect on the next mismatched cycle.
    // Disabling from any state drops straight to OFF, so the 0 produced by
    // the disabled pad never reaches the level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (EN_I) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!EN_I) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    lvl_d   = s;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!EN_I) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (s == lvl_q) begin
                    cnt_d = '0;
                end else if (cnt_q >= DBNC_I) begin
                    lvl_d  = s;
                    cnt_d  = '0;
                    rise_d = s;
                    fall_d = ~s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        ie_d  = (state_d != ST_OFF);

        // A set in the same cycle as a clear wins.
        irq_d = (rise_d & EVT_MASK_I[0]) | (fall_d & EVT_MASK_I[1]) |
                (irq_q & ~IRQ_CLR_I);
    end

    assign IE_O   = ie_q;
    assign STE_O  = ste_q;
    assign LVL_O  = lvl_q;
    assign RISE_O = rise_q;
    assign FALL_O = fall_q;
    assign IRQ_O  = irq_q;

endmodule
